// File: rtl/ysyx_22041752_dcache_meta.sv
// ysyx_22041752_dcache_meta
// Valid/dirty metadata for the N-way data cache. Each set holds one valid
// bit and one dirty bit per way, plus a FIFO victim pointer. Read-out is
// registered.
//
// Optional flush walker, enabled by defining YSYX_22041752_DCACHE_FLUSH_EN.
// The walker scans every {idx,way} entry, way-minor. It hands each
// valid&dirty line to the cache FSM through wb_req_o/wb_ack_i and clears
// every entry it passes. When the scan finishes it resets all victim
// pointers.
//
// Ports
//   clk_i, rst_i          clock; asynchronous active-high reset
//   rd_en_i, rd_idx_i     read strobe and set
//   rd_valid_o/dirty_o    registered valid/dirty bits of the set that was read
//   rd_victim_o           registered victim pointer of the set that was read
//   wr_en_i, wr_idx_i,    write strobe, set and way
//   wr_way_i
//   wr_valid_i/dirty_i    new valid/dirty bit
//   wr_fill_i             also advance the victim pointer of wr_idx_i
//   flush_req_i           start a flush
//   flush_busy_o          walker active
//   flush_done_o          one-cycle pulse when the flush ends
//   wb_req_o, wb_idx_o,   dirty line waiting for writeback
//   wb_way_o
//   wb_ack_i              writeback accepted
module ysyx_22041752_dcache_meta #(
  parameter  int WAYS  = 2,
  parameter  int SETS  = 64,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [WAYS-1:0]  rd_valid_o,
  output logic [WAYS-1:0]  rd_dirty_o,
  output logic [WAY_W-1:0] rd_victim_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [WAY_W-1:0] wr_way_i,
  input  logic             wr_valid_i,
  input  logic             wr_dirty_i,
  input  logic             wr_fill_i,
  input  logic             flush_req_i,
  output logic             flush_busy_o,
  output logic             flush_done_o,
  output logic             wb_req_o,
  output logic [IDX_W-1:0] wb_idx_o,
  output logic [WAY_W-1:0] wb_way_o,
  input  logic             wb_ack_i
);

  logic [WAYS-1:0]  valid_q  [SETS];
  logic [WAYS-1:0]  dirty_q  [SETS];
  logic [WAY_W-1:0] victim_q [SETS];
  logic [WAYS-1:0]  rd_valid_q, rd_dirty_q;
  logic [WAY_W-1:0] rd_victim_q;

  logic [WAY_W-1:0] victim_cur, victim_nxt;
  logic             clr_entry, clr_victim, busy;
  logic [IDX_W-1:0] clr_idx;
  logic [WAY_W-1:0] clr_way;

  always_comb begin
    victim_cur = victim_q[wr_idx_i];
    if (WAYS == 1 || victim_cur == WAY_W'(WAYS - 1)) victim_nxt = '0;
    else victim_nxt = victim_cur + WAY_W'(1);
  end

`ifdef YSYX_22041752_DCACHE_FLUSH_EN
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic [WAY_W-1:0] fway_q, fway_d;
  logic             entry_dirty, last_entry, adv;

  assign entry_dirty = valid_q[fidx_q][fway_q] & dirty_q[fidx_q][fway_q];
  assign last_entry  = (fidx_q == IDX_W'(SETS - 1)) && (fway_q == WAY_W'(WAYS - 1));

  always_comb begin
    state_d    = state_q;
    fidx_d     = fidx_q;
    fway_d     = fway_q;
    clr_entry  = 1'b0;
    clr_victim = 1'b0;
    adv        = 1'b0;
    case (state_q)
      S_IDLE: if (flush_req_i) begin
        state_d = S_SCAN;
        fidx_d  = '0;
        fway_d  = '0;
      end
      S_SCAN: if (entry_dirty) state_d = S_WAIT;
              else begin
                clr_entry = 1'b1;
                adv       = 1'b1;
              end
      S_WAIT: if (wb_ack_i) begin
        clr_entry = 1'b1;
        adv       = 1'b1;
      end
      default: begin
        clr_victim = 1'b1;
        state_d    = S_IDLE;
        fidx_d     = '0;
        fway_d     = '0;
      end
    endcase
    // The entry just cleared was the last one, so the walk ends.
    // Otherwise step to the next entry, way-minor.
    if (adv) begin
      if (last_entry) state_d = S_DONE;
      else begin
        state_d = S_SCAN;
        if (fway_q == WAY_W'(WAYS - 1)) begin
          fway_d = '0;
          fidx_d = fidx_q + IDX_W'(1);
        end else fway_d = fway_q + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      fidx_q  <= '0;
      fway_q  <= '0;
    end else begin
      state_q <= state_d;
      fidx_q  <= fidx_d;
      fway_q  <= fway_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign clr_idx      = fidx_q;
  assign clr_way      = fway_q;
  assign flush_done_o = (state_q == S_DONE);
  assign wb_req_o     = (state_q == S_WAIT);
  assign wb_idx_o     = fidx_q;
  assign wb_way_o     = fway_q;
`else
  logic unused_flush_in;
  assign unused_flush_in = flush_req_i ^ wb_ack_i;
  assign busy         = 1'b0;
  assign clr_entry    = 1'b0;
  assign clr_victim   = 1'b0;
  assign clr_idx      = '0;
  assign clr_way      = '0;
  assign flush_done_o = 1'b0;
  assign wb_req_o     = 1'b0;
  assign wb_idx_o     = '0;
  assign wb_way_o     = '0;
`endif

  // Reads sample the arrays before this edge's write, so a read and a
  // write to the same set in one cycle return the old contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s]  <= '0;
        dirty_q[s]  <= '0;
        victim_q[s] <= '0;
      end
      rd_valid_q  <= '0;
      rd_dirty_q  <= '0;
      rd_victim_q <= '0;
    end else begin
      if (rd_en_i) begin
        rd_valid_q  <= valid_q[rd_idx_i];
        rd_dirty_q  <= dirty_q[rd_idx_i];
        rd_victim_q <= victim_q[rd_idx_i];
      end
      if (wr_en_i && !busy) begin
        valid_q[wr_idx_i][wr_way_i] <= wr_valid_i;
        dirty_q[wr_idx_i][wr_way_i] <= wr_dirty_i;
        if (wr_fill_i) victim_q[wr_idx_i] <= victim_nxt;
      end
      if (clr_entry) begin
        valid_q[clr_idx][clr_way] <= 1'b0;
        dirty_q[clr_idx][clr_way] <= 1'b0;
      end
      if (clr_victim) begin
        for (int s = 0; s < SETS; s++) victim_q[s] <= '0;
      end
    end
  end

  assign rd_valid_o   = rd_valid_q;
  assign rd_dirty_o   = rd_dirty_q;
  assign rd_victim_o  = rd_victim_q;
  assign flush_busy_o = busy;

endmodule

// File: tb/tb_ysyx_22041752_dcache_meta.sv
// Directed bench for ysyx_22041752_dcache_meta (WAYS=2, SETS=64).
// The flush checks are built only when YSYX_22041752_DCACHE_FLUSH_EN is
// defined. Otherwise the bench checks that the flush ports stay inert.
module tb_ysyx_22041752_dcache_meta;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rd_en_i;
  logic [5:0] rd_idx_i;
  logic [1:0] rd_valid_o, rd_dirty_o;
  logic [0:0] rd_victim_o;
  logic       wr_en_i;
  logic [5:0] wr_idx_i;
  logic [0:0] wr_way_i;
  logic       wr_valid_i, wr_dirty_i, wr_fill_i;
  logic       flush_req_i, flush_busy_o, flush_done_o;
  logic       wb_req_o;
  logic [5:0] wb_idx_o;
  logic [0:0] wb_way_o;
  logic       wb_ack_i;

  int n_cmp = 0;
  int n_mis = 0;

  ysyx_22041752_dcache_meta #(.WAYS(2), .SETS(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i),
    .rd_valid_o(rd_valid_o), .rd_dirty_o(rd_dirty_o), .rd_victim_o(rd_victim_o),
    .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i), .wr_way_i(wr_way_i),
    .wr_valid_i(wr_valid_i), .wr_dirty_i(wr_dirty_i), .wr_fill_i(wr_fill_i),
    .flush_req_i(flush_req_i), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
    .wb_req_o(wb_req_o), .wb_idx_o(wb_idx_o), .wb_way_o(wb_way_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic wr(input logic [5:0] idx, input logic w, input logic v, input logic d,
                    input logic f);
    wr_en_i = 1'b1; wr_idx_i = idx; wr_way_i = w;
    wr_valid_i = v; wr_dirty_i = d; wr_fill_i = f;
    tick();
    wr_en_i = 1'b0; wr_fill_i = 1'b0;
  endtask

  task automatic rd(input logic [5:0] idx);
    rd_en_i = 1'b1; rd_idx_i = idx;
    tick();
    rd_en_i = 1'b0;
  endtask

  // Number of ticks until wb_req_o rises. A timeout counts as a failed check.
  task automatic wait_wb(input int budget, inout int cnt);
    int k = 0;
    while (!wb_req_o && k < budget) begin
      tick();
      cnt++;
      k++;
    end
    if (!wb_req_o) chk("wb_req_timeout", 0, 1);
  endtask

  task automatic pulse_flush();
    flush_req_i = 1'b1;
    tick();
    flush_req_i = 1'b0;
  endtask

  initial begin
    int cnt;
    int seen;
    logic [31:0] acc;
    rst_i = 1'b0; rd_en_i = 1'b0; rd_idx_i = '0; wr_en_i = 1'b0; wr_idx_i = '0;
    wr_way_i = '0; wr_valid_i = 1'b0; wr_dirty_i = 1'b0; wr_fill_i = 1'b0;
    flush_req_i = 1'b0; wb_ack_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_rd_valid", 32'(rd_valid_o), 0);
    chk("rst_busy", 32'(flush_busy_o), 0);
    chk("rst_done", 32'(flush_done_o), 0);
    chk("rst_wb_req", 32'(wb_req_o), 0);
    chk("rst_wb_idx", 32'({wb_idx_o, wb_way_o}), 0);
    tick();
    rst_i = 1'b0;

    rd(6'd5);
    chk("rd5_valid", 32'(rd_valid_o), 0);
    chk("rd5_dirty", 32'(rd_dirty_o), 0);
    chk("rd5_victim", 32'(rd_victim_o), 0);

    wr(6'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    rd(6'd5);
    chk("wr5_valid", 32'(rd_valid_o), 2);
    chk("wr5_dirty", 32'(rd_dirty_o), 2);
    chk("wr5_victim", 32'(rd_victim_o), 1);
    wr(6'd5, 1'b0, 1'b1, 1'b0, 1'b1);
    rd(6'd5);
    chk("wrap5_valid", 32'(rd_valid_o), 3);
    chk("wrap5_dirty", 32'(rd_dirty_o), 2);
    chk("wrap5_victim", 32'(rd_victim_o), 0);
    rd_idx_i = 6'd0;
    tick();
    chk("hold_valid", 32'(rd_valid_o), 3);

    // Read and write of set 9 in the same cycle.
    rd_en_i = 1'b1; rd_idx_i = 6'd9;
    wr(6'd9, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rw9_old_valid", 32'(rd_valid_o), 0);
    rd(6'd9);
    chk("rw9_new_valid", 32'(rd_valid_o), 1);
    chk("rw9_new_dirty", 32'(rd_dirty_o), 1);

`ifdef YSYX_22041752_DCACHE_FLUSH_EN
    // Flush of a clean table. Valid-clean and dirty-invalid entries must
    // not raise wb_req.
    do_reset();
    wr(6'd10, 1'b1, 1'b1, 1'b0, 1'b1);
    wr(6'd20, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_flush();
    chk("clean_busy_at_accept", 32'(flush_busy_o), 1);
    cnt = 0; seen = 0;
    while (!flush_done_o && cnt < 300) begin
      tick();
      cnt++;
      if (wb_req_o) seen++;
    end
    chk("clean_done_cycle", 32'(cnt), 128);
    chk("clean_no_wb_req", 32'(seen), 0);
    tick();
    chk("clean_busy_fall", 32'(flush_busy_o), 0);
    chk("clean_done_pulse", 32'(flush_done_o), 0);
    acc = '0;
    for (int s = 0; s < 64; s++) begin
      rd(6'(s));
      acc = acc | 32'({rd_valid_o, rd_dirty_o, rd_victim_o});
    end
    chk("clean_all_zero", acc, 0);

    // Dirty lines at (3,0) = entry 6 and (63,1) = entry 127.
    wr(6'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    wr(6'd63, 1'b1, 1'b1, 1'b1, 1'b0);
    wr(6'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    pulse_flush();
    cnt = 0;
    wait_wb(300, cnt);
    chk("wb1_latency", 32'(cnt), 7);
    chk("wb1_idx", 32'(wb_idx_o), 3);
    chk("wb1_way", 32'(wb_way_o), 0);
    // This write lands on a later entry. It must not raise an extra wb_req.
    wr(6'd40, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    chk("wb1_hold_req", 32'(wb_req_o), 1);
    chk("wb1_hold_idx", 32'({wb_idx_o, wb_way_o}), 32'({6'd3, 1'b0}));
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("wb1_req_low", 32'(wb_req_o), 0);
    rd(6'd3);
    chk("wb1_entry_cleared", 32'({rd_valid_o, rd_dirty_o}), 0);
    cnt = 1;
    wait_wb(300, cnt);
    chk("wb2_latency", 32'(cnt), 121);
    chk("wb2_idx", 32'(wb_idx_o), 63);
    chk("wb2_way", 32'(wb_way_o), 1);
    tick(); tick(); tick();
    chk("wb2_hold_req", 32'(wb_req_o), 1);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("wb2_done", 32'(flush_done_o), 1);
    chk("wb2_req_low", 32'(wb_req_o), 0);
    tick();
    chk("wb2_busy_fall", 32'(flush_busy_o), 0);
    rd(6'd63);
    chk("wb2_entry_cleared", 32'({rd_valid_o, rd_dirty_o}), 0);
    rd(6'd40);
    chk("blocked_write", 32'({rd_valid_o, rd_dirty_o}), 0);

    // Reset while in WAIT_ACK, then restart from entry 0.
    wr(6'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    pulse_flush();
    cnt = 0;
    wait_wb(20, cnt);
    chk("rstw_wb_req", 32'(wb_req_o), 1);
    rst_i = 1'b1;
    #1;
    chk("rstw_req_drop", 32'(wb_req_o), 0);
    chk("rstw_busy_drop", 32'(flush_busy_o), 0);
    #1;
    rst_i = 1'b0;
    rd(6'd0);
    chk("rstw_table_zero", 32'({rd_valid_o, rd_dirty_o}), 0);
    wr(6'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_flush();
    cnt = 0;
    wait_wb(300, cnt);
    chk("restart_latency", 32'(cnt), 5);
    chk("restart_idx", 32'({wb_idx_o, wb_way_o}), 32'({6'd2, 1'b0}));
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    cnt = 0;
    while (!flush_done_o && cnt < 300) begin
      tick();
      cnt++;
    end
    chk("restart_done", 32'(flush_done_o), 1);
    tick();
`else
    // Without the walker, flush_req is inert and writes are never blocked.
    flush_req_i = 1'b1;
    wr(6'd12, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("nf_busy", 32'(flush_busy_o), 0);
    chk("nf_done", 32'(flush_done_o), 0);
    chk("nf_wb_req", 32'(wb_req_o), 0);
    flush_req_i = 1'b0;
    rd(6'd12);
    chk("nf_write_taken", 32'(rd_valid_o), 2);
    chk("nf_dirty_taken", 32'(rd_dirty_o), 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/ysyx_22041752_dcache_meta.md
# ysyx_22041752_dcache_meta

Parametrised valid/dirty metadata table for the N-way data cache. It holds one valid bit and one dirty bit per way per set, plus a per-set FIFO victim pointer, with registered read-out. It also contains an optional flush walker that scans every entry, hands dirty lines to the cache FSM for writeback through a req/ack handshake, and invalidates the whole table. It sits beside the tag and data SRAMs inside the DCACHE and is driven by the cache control FSM.

## Interface
- WAYS, 2, associativity; legal values 1, 2, 4
- SETS, 64, number of sets; power of two, ≥2
- IDX_W, $clog2(SETS), set index width (derived; do not override)
- WAY_W, max(1,$clog2(WAYS)), way index width (derived)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rd_en  in  1  active-high read strobe
- rd_idx  in  IDX_W  read set index
- rd_valid  out  WAYS  registered valid bits of set rd_idx
- rd_dirty  out  WAYS  registered dirty bits of set rd_idx
- rd_victim  out  WAY_W  registered victim pointer of set rd_idx
- wr_en  in  1  active-high write strobe
- wr_idx  in  IDX_W  write set index
- wr_way  in  WAY_W  write way
- wr_valid  in  1  new valid bit
- wr_dirty  in  1  new dirty bit
- wr_fill  in  1  with wr_en: advance victim pointer of wr_idx (mod WAYS)
- flush_req  in  1  start flush (pulse or level)
- flush_busy  out  1  walker active
- flush_done  out  1  one-cycle pulse at flush end
- wb_req  out  1  dirty line awaiting writeback
- wb_idx  out  IDX_W  set of the dirty line
- wb_way  out  WAY_W  way of the dirty line
- wb_ack  in  1  writeback accepted

## Operation
- Storage: valid[SETS][WAYS], dirty[SETS][WAYS], victim[SETS]; all flops, all 0 on reset.
- Read: on rd_en, rd_valid/rd_dirty/rd_victim load the set contents at the next edge; without rd_en, they hold.
- Write: on wr_en, valid/dirty of (wr_idx, wr_way) take wr_valid/wr_dirty. With wr_fill also set, victim[wr_idx] increments and wraps WAYS-1→0. With WAYS=1, victim stays 0.
- Read and write to the same set in one cycle: read returns the pre-write value.
- Flush FSM states: IDLE, SCAN, WAIT_ACK, DONE. Counter {idx,way} is IDX_W+WAY_W bits, way-minor.
  - IDLE: flush_req → SCAN with counter 0.
  - SCAN, entry valid&dirty: → WAIT_ACK.
  - SCAN, entry not valid&dirty: clear valid+dirty, then increment, or go to DONE if the entry was the last.
  - WAIT_ACK: wb_req=1, wb_idx/wb_way = counter, stable until wb_ack. On wb_ack, clear valid+dirty, then increment and → SCAN, or go to DONE if the entry was the last.
  - DONE: flush_done=1; all victim pointers reset to 0; → IDLE.
- flush_busy=1 in SCAN, WAIT_ACK and DONE.
- wr_en is ignored while flush_busy. rd_en is still served and returns live contents.
- flush_req while busy is ignored. wb_ack outside WAIT_ACK is ignored.
- Reset at any point, including mid-flush: table cleared, FSM → IDLE, all outputs 0 asynchronously.

## Timing
- Read latency is 1 cycle. Write takes effect at the edge it is sampled and is visible to a read issued the next cycle.
- Flush accepted at edge T: flush_busy=1 from T. A clean entry costs 1 cycle.
- A dirty entry costs 1 SCAN cycle plus the WAIT_ACK cycles. wb_req rises 1 cycle after the entry is scanned. Ack at edge A: wb_req low after A.
- Fully clean table: flush_done pulses in cycle SETS*WAYS after acceptance; flush_busy falls 1 cycle after that.
- Reset values: rd_valid=0, rd_dirty=0, rd_victim=0, flush_busy=0, flush_done=0, wb_req=0, wb_idx=0, wb_way=0.

## Configuration
- YSYX_22041752_DCACHE_FLUSH_EN defined: flush walker compiled in as above.
- Not defined: no FSM or counter. flush_req and wb_ack are ignored. flush_busy, flush_done and wb_req are tied 0, wb_idx and wb_way are tied 0. wr_en is never blocked.

## Test plan
- Reset then read set 5 → rd_valid=2'b00, rd_dirty=2'b00, rd_victim=0 one cycle after rd_en.
- Write (idx 5, way 1, v=1, d=1, fill) then read idx 5 → rd_valid=2'b10, rd_dirty=2'b10, rd_victim=1. A second fill wraps rd_victim to 0.
- Same-cycle read and write of idx 9 → read returns old value. A read on the next cycle returns the new value.
- FLUSH_EN, table clean, flush_req → flush_done pulses exactly 128 cycles after acceptance, wb_req never asserts, all entries read back 0.
- FLUSH_EN, dirty lines at (3,0) and (63,1), wb_ack delayed 4 cycles each → wb_req shows idx 3 way 0, then idx 63 way 1. wb_req holds until ack, the entries are cleared afterwards, and wr_en during the flush has no effect.
- Assert reset while in WAIT_ACK → wb_req and flush_busy drop immediately, table reads all-zero, and a new flush_req restarts from entry 0.
